// File: rtl/aes_spi_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_sequencer_pkg
// Purpose  : Shared definitions for the AES SPI sequencer: key_len
//            encodings, key-length lookup, header bit positions, FSM state
//            encoding and the default block size.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_spi_sequencer_pkg;

  localparam logic [1:0] c_key_len_128 = 2'b00;
  localparam logic [1:0] c_key_len_192 = 2'b01;
  localparam logic [1:0] c_key_len_256 = 2'b10;
  localparam logic [1:0] c_key_len_inv = 2'b11;

  // Header byte layout: {mode, key-length-in-bytes[6:0]}
  localparam int c_hdr_mode_bit  = 7;
  localparam int c_block_bytes   = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_BYTE  = 3'd1,
    ST_TX_WAIT  = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_RX_BYTE  = 3'd5,
    ST_RX_WAIT  = 3'd6,
    ST_FINISH   = 3'd7
  } state_t;

  // Key length in bytes; zero marks the invalid encoding.
  function automatic logic [5:0] kb_of(input logic [1:0] key_len);
    case (key_len)
      c_key_len_128: return 6'd16;
      c_key_len_192: return 6'd24;
      c_key_len_256: return 6'd32;
      default:       return 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] header_byte(input logic mode, input logic [5:0] kb);
    logic [7:0] h;
    h = {2'b00, kb};
    h[c_hdr_mode_bit] = mode;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_seq_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : aes_seq_cycle_timer
// Purpose  : Loadable down-counter with expire flag, shared by the inter-byte
//            gap and the result-ready timeout of the AES SPI sequencer.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            load_i          - load load_val_i (has priority over en_i)
//            load_val_i      - value to load
//            en_i            - decrement by one (saturates at zero)
//            expired_o       - count is at or below one
// Revision : 1.0 - initial release
// ============================================================================
module aes_seq_cycle_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiring at one means a load of N keeps the caller in its state for
  // exactly N enabled cycles.
  assign expired_o = (count_q <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/aes_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_sequencer
// Purpose  : Moves one AES block through an SPI master byte interface to an
//            AES slave: 16 text bytes, a header byte, 16/24/32 key bytes,
//            waits for the slave's result flag, then reads 16 result bytes.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            go, mode, key_len        - request, 0=enc/1=dec, key size
//            text_in, key_in          - block (byte 0 = MSB), right-aligned key
//            text_out, busy, done, err - result and status
//            spi_start, spi_tx        - byte request / byte to send
//            spi_busy, spi_done, spi_rx - master status / received byte
//            slv_result_rdy           - slave result available
// Options  : AES_SEQ_CHECK_EN adds expected_in / match result compare.
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_sequencer
  import aes_spi_sequencer_pkg::*;
#(
  parameter int BLOCK_BYTES    = c_block_bytes,
  parameter int MAX_KEY_BYTES  = 32,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       mode,
  input  logic [1:0]                 key_len,
  input  logic [BLOCK_BYTES*8-1:0]   text_in,
  input  logic [MAX_KEY_BYTES*8-1:0] key_in,
  output logic [BLOCK_BYTES*8-1:0]   text_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       spi_start,
  output logic [7:0]                 spi_tx,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  input  logic [7:0]                 spi_rx,
  input  logic                       slv_result_rdy
`ifdef AES_SEQ_CHECK_EN
  ,
  input  logic [BLOCK_BYTES*8-1:0]   expected_in,
  output logic                       match
`endif
);

  localparam int c_txt_w = BLOCK_BYTES * 8;
  localparam int c_key_w = MAX_KEY_BYTES * 8;
  localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmr_w-1:0] c_gap_load = c_tmr_w'(GAP_CYCLES);
  // Two cycles are spent outside WAIT_RES (FINISH and the done register), so
  // done lands exactly TIMEOUT_CYCLES after the last transmit spi_done.
  localparam logic [c_tmr_w-1:0] c_timeout_load = c_tmr_w'(TIMEOUT_CYCLES - 2);

  state_t               state_q;
  state_t               ret_q;
  logic                 mode_q;
  logic [5:0]           kb_q;
  logic [5:0]           rem_q;
  logic [c_txt_w-1:0]   text_q;
  logic [c_key_w-1:0]   key_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 err_pend_q;
  logic                 spi_start_q;
  logic [7:0]           spi_tx_q;
  logic [c_txt_w-1:0]   text_out_q;

  logic [5:0]           w_kb;
  logic                 w_tmr_load;
  logic [c_tmr_w-1:0]   w_tmr_val;
  logic                 w_tmr_en;
  logic                 w_tmr_expired;

  assign w_kb = kb_of(key_len);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = c_gap_load;
    w_tmr_en   = 1'b0;
    case (state_q)
      ST_TX_WAIT: begin
        if (spi_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (rem_q == 6'd1) ? c_timeout_load : c_gap_load;
        end
      end
      ST_RX_WAIT:           w_tmr_load = spi_done;
      ST_GAP, ST_WAIT_RES:  w_tmr_en   = 1'b1;
      default:              ;
    endcase
  end

  aes_seq_cycle_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .en_i       (w_tmr_en),
    .expired_o  (w_tmr_expired)
  );

`ifdef AES_SEQ_CHECK_EN
  logic [c_txt_w-1:0] expected_q;
  logic               match_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      mode_q      <= 1'b0;
      kb_q        <= '0;
      rem_q       <= '0;
      text_q      <= '0;
      key_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_pend_q  <= 1'b0;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'h00;
      text_out_q  <= '0;
`ifdef AES_SEQ_CHECK_EN
      expected_q  <= '0;
      match_q     <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      spi_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            mode_q     <= mode;
            kb_q       <= w_kb;
            rem_q      <= 6'(BLOCK_BYTES + 1) + w_kb;
            text_q     <= text_in;
            // MSB-align the key so bytes always leave from the top.
            key_q      <= key_in << ((MAX_KEY_BYTES - int'(w_kb)) * 8);
            err_q      <= 1'b0;
`ifdef AES_SEQ_CHECK_EN
            expected_q <= expected_in;
`endif
            if (key_len == c_key_len_inv) begin
              err_pend_q <= 1'b1;
              state_q    <= ST_FINISH;
            end else begin
              err_pend_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= ST_TX_BYTE;
            end
          end
        end
        ST_TX_BYTE: begin
          if (!spi_busy) begin
            spi_start_q <= 1'b1;
            // rem_q counts down through text, then the header, then the key.
            if (rem_q > kb_q + 6'd1) begin
              spi_tx_q <= text_q[c_txt_w-1 -: 8];
              text_q   <= text_q << 8;
            end else if (rem_q == kb_q + 6'd1) begin
              spi_tx_q <= header_byte(mode_q, kb_q);
            end else begin
              spi_tx_q <= key_q[c_key_w-1 -: 8];
              key_q    <= key_q << 8;
            end
            state_q <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          if (spi_done) begin
            rem_q <= rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              state_q <= ST_WAIT_RES;
            end else begin
              ret_q   <= ST_TX_BYTE;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (w_tmr_expired) begin
            state_q <= ret_q;
          end
        end
        ST_WAIT_RES: begin
          if (slv_result_rdy) begin
            rem_q   <= 6'(BLOCK_BYTES);
            state_q <= ST_RX_BYTE;
          end else if (w_tmr_expired) begin
            err_pend_q <= 1'b1;
            state_q    <= ST_FINISH;
          end
        end
        ST_RX_BYTE: begin
          spi_start_q <= 1'b1;
          spi_tx_q    <= 8'h00;
          state_q     <= ST_RX_WAIT;
        end
        ST_RX_WAIT: begin
          if (spi_done) begin
            // Shift in: after the last byte, byte 0 sits in the top lane.
            text_out_q <= {text_out_q[c_txt_w-9:0], spi_rx};
            rem_q      <= rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              state_q <= ST_FINISH;
            end else begin
              ret_q   <= ST_RX_BYTE;
              state_q <= ST_GAP;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          err_q   <= err_pend_q;
`ifdef AES_SEQ_CHECK_EN
          match_q <= (text_out_q == expected_q) && !err_pend_q;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign text_out  = text_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign spi_start = spi_start_q;
  assign spi_tx    = spi_tx_q;
`ifdef AES_SEQ_CHECK_EN
  assign match     = match_q;
`endif

endmodule
`default_nettype wire

// File: doc/aes_spi_sequencer.md
Name: aes_spi_sequencer

Overview:
Synthesizable transaction sequencer that moves one AES block through the SPI master byte interface to an AES slave (encrypt or decrypt core) and collects the result.
- Sends: 16 text bytes, 1 header byte, then 16/24/32 key bytes.
- Waits for the slave's result-ready flag, then clocks back 16 result bytes.
- Sits between the system controller and `master`; generalises the fixed 256-bit encrypt-only sequencing to runtime key length, runtime mode, inter-byte gap and timeout.

Parameters:
BLOCK_BYTES, 16, text/result length in bytes.
MAX_KEY_BYTES, 32, width of key_in in bytes.
GAP_CYCLES, 8, idle clk cycles between end of one SPI byte and next spi_start (slave processing time).
TIMEOUT_CYCLES, 4096, max clk cycles waiting for slv_result_rdy before abort.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0=encrypt, 1=decrypt
key_len  in  2  00=128, 01=192, 10=256, 11=invalid
text_in  in  128  plaintext/ciphertext, byte 0 = [127:120]
key_in  in  256  key, right-aligned: KB-byte key occupies [KB*8-1:0]
text_out  out  128  received result, first byte into [127:120]
busy  out  1  high from go-accept until done
done  out  1  one-cycle pulse at end (success or error)
err  out  1  valid with done: invalid key_len or timeout
spi_start  out  1  one-cycle byte-transfer request to master
spi_tx  out  8  byte to transmit
spi_busy  in  1  master busy
spi_done  in  1  one-cycle pulse, byte complete
spi_rx  in  8  received byte, valid with spi_done
slv_result_rdy  in  1  slave has a result to return

Behaviour:
- Reset values: busy=0, done=0, err=0, spi_start=0, spi_tx=8'h00, text_out=0, state=IDLE, all counters 0.
- Reset asserted mid-operation: abort immediately to IDLE with reset values; no done pulse.
- KB: 16/24/32 from key_len.
- Header byte: {mode, KB[6:0]}, i.e. 0x10/0x18/0x20 encrypt, 0x90/0x98/0xA0 decrypt.
- States:
  - IDLE: on go, latch mode/key_len/text_in/key_in. If key_len==11, go to FINISH with err=1 and send no bytes. Otherwise busy=1, go to TX_BYTE.
  - TX_BYTE: wait for !spi_busy. Then pulse spi_start for exactly 1 cycle with spi_tx = current byte. Order: text bytes 0..15 MSB-first, header, key bytes key_in[KB*8-1 -: 8] downward to [7:0]. Go to TX_WAIT.
  - TX_WAIT: on spi_done, decrement remaining count (starts at 17+KB). If zero, go to WAIT_RES; else go to GAP, then TX_BYTE.
  - GAP: count GAP_CYCLES cycles, then return to the calling state (TX_BYTE or RX_BYTE).
  - WAIT_RES: count cycles. If slv_result_rdy, go to RX_BYTE. If count reaches TIMEOUT_CYCLES first, set err=1 and go to FINISH. If both happen in the same cycle, slv_result_rdy wins.
  - RX_BYTE: pulse spi_start with spi_tx=8'h00 (dummy). Go to RX_WAIT.
  - RX_WAIT: on spi_done, store spi_rx at result byte index 0..15 (index 0 = [127:120]). After byte 15 go to FINISH; else go to GAP, then RX_BYTE.
  - FINISH: done=1 for 1 cycle, busy=0, go to IDLE. text_out holds until the next accepted go (not cleared on error).
- go while busy: ignored.
- spi_done outside TX_WAIT/RX_WAIT: ignored.
- Latched inputs: changes to text_in/key_in/mode after accept do not affect the transaction.
- Counters: byte counter 6 bits; gap/timeout counter sized by $clog2(TIMEOUT_CYCLES+1); no wrap permitted.
- Minimum latency from go: (17+KB+16) bytes × (SPI byte time + GAP_CYCLES + 2) + wait for result.

Optional Feature:
AES_SEQ_CHECK_EN.
- Defined: adds input expected_in[127:0] (latched at go) and output match (1 bit, reset 0). match is registered in FINISH as (text_out == expected_in) && !err, and is valid with done.
- Undefined: neither port exists; no comparator logic is generated.

Decomposition:
- Shared include aes_seq_defs.vh holds: key_len encodings, KB lookup, header bit positions (mode=bit 7), state encodings, BLOCK_BYTES default.
- One sub-module, aes_seq_cycle_timer: loadable down-counter with expire flag, shared by GAP and WAIT_RES.

Test Plan:
- Encrypt, key_len=10, key 000102…1e1f, text 00112233445566778899aabbccddeeff -> 49 tx bytes, header 0x20; text_out=8ea2b7ca516745bfeafc49904b496089; done pulse, err=0.
- Encrypt, key_len=00, key 000102…0f -> 33 tx bytes, header 0x10; text_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt, key_len=01, key 000102…17, text dda97ca4864cdfe06eaf70a0ec0d7191 -> header 0x98; text_out=00112233445566778899aabbccddeeff.
- key_len=11 -> no spi_start ever; done and err high 2 cycles after go.
- slv_result_rdy held low -> err=1 and done exactly TIMEOUT_CYCLES cycles after the last tx spi_done; a second go mid-transfer is ignored.
- reset asserted during the 10th tx byte -> next cycle busy=0, spi_start=0; a subsequent go completes normally (with AES_SEQ_CHECK_EN, match=1 on correct expected_in, 0 on a single flipped bit).
